// File: rtl/wb_trace_capture_if.sv
// Writeback port plus trace drain handshake between the CPU, the capture unit and the debug host.
// The slave modport is the capture unit's view; the master modport drives writebacks and accepts trace entries.
interface wb_trace_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int SEQ_W  = 8
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [SEQ_W-1:0]  out_seq;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output wb_we, wb_addr, wb_data, out_ready,
    input  out_valid, out_seq, out_addr, out_data
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, out_ready,
    output out_valid, out_seq, out_addr, out_data
  );
endinterface

// File: rtl/wb_trace_capture.sv
// Shadows the register file and queues sequence-stamped writeback events; entry visible the cycle after capture.
// Backpressure: a full FIFO with no pop drops the event and sets sticky overflow; seq still advances.
module wb_trace_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage is reset too so the head fields read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module wb_trace_capture #(
  parameter int  DEPTH  = 8,
  parameter int  DATA_W = 8,
  parameter int  ADDR_W = 2,
  parameter int  SEQ_W  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  wb_trace_capture_if.slave   bus,
  input  logic                cap_en,
  input  logic                filter_en,
  input  logic                ovf_clr,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  input  logic [ADDR_W-1:0]   shadow_sel,
  output logic [DATA_W-1:0]   shadow_data
);
  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] shadow [NREG];
  logic [NREG-1:0]   sh_vld;
  logic [SEQ_W-1:0]  seq;
  logic              changed;
  logic              qualify;
  logic              pop;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  entry_t            push_entry;
  entry_t            head_entry;

  // Filter compares against the value before this cycle's write lands.
  assign changed = !sh_vld[bus.wb_addr] || (bus.wb_data != shadow[bus.wb_addr]);
  assign qualify = cap_en && bus.wb_we && (!filter_en || changed);
  assign pop     = bus.out_valid && bus.out_ready;
  assign push    = qualify && (!fifo_full || pop);
  assign drop    = qualify && fifo_full && !pop;

  always_comb begin
    push_entry      = '0;
    push_entry.seq  = seq;
    push_entry.addr = bus.wb_addr;
    push_entry.data = bus.wb_data;
  end

  wb_trace_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head_entry),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_seq   = head_entry.seq;
  assign bus.out_addr  = head_entry.addr;
  assign bus.out_data  = head_entry.data;
  assign shadow_data   = shadow[shadow_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
      sh_vld <= '0;
    end else if (bus.wb_we) begin
      shadow[bus.wb_addr] <= bus.wb_data;
      sh_vld[bus.wb_addr] <= 1'b1;
    end
  end

  // Dropped events still consume a sequence number so the host can see the gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      if (qualify) seq <= seq + SEQ_W'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture with a queue scoreboard and a small reference model.
module tb_wb_trace_capture;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int SEQ_W  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct {
    int seq;
    int addr;
    int data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              cap_en;
  logic              filter_en;
  logic              ovf_clr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [ADDR_W-1:0] shadow_sel;
  logic [DATA_W-1:0] shadow_data;

  wb_trace_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEQ_W(SEQ_W)) bus ();

  wb_trace_capture #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SEQ_W  (SEQ_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cap_en      (cap_en),
    .filter_en   (filter_en),
    .ovf_clr     (ovf_clr),
    .count       (count),
    .overflow    (overflow),
    .shadow_sel  (shadow_sel),
    .shadow_data (shadow_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   m_sh [4];
  bit   m_vld [4];
  int   m_seq;
  int   m_count;
  int   m_ovf;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = 0;
      m_vld[i] = 1'b0;
    end
    m_seq   = 0;
    m_count = 0;
    m_ovf   = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one writeback; with pop=1 the current head is also accepted in the same cycle.
  task automatic wb_write(input int a, input int d, input bit pop);
    bit   qual;
    exp_t e;
    exp_t h;
    @(negedge clk);
    qual = cap_en && (!filter_en || !m_vld[a] || m_sh[a] != d);
    if (pop) begin
      check("pop_valid", 32'(bus.out_valid), 1);
      h = sb_q.pop_front();
      check("pop_seq",  32'(bus.out_seq),  h.seq);
      check("pop_addr", 32'(bus.out_addr), h.addr);
      check("pop_data", 32'(bus.out_data), h.data);
      m_count--;
    end
    if (qual) begin
      if (m_count < DEPTH) begin
        e.seq = m_seq; e.addr = a; e.data = d;
        sb_q.push_back(e);
        m_count++;
      end else begin
        m_ovf = 1;
      end
      m_seq = (m_seq + 1) % 256;
    end
    m_sh[a]  = d;
    m_vld[a] = 1'b1;
    bus.wb_we     = 1'b1;
    bus.wb_addr   = ADDR_W'(a);
    bus.wb_data   = DATA_W'(d);
    bus.out_ready = pop;
    @(posedge clk);
    #1;
    bus.wb_we     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic drain_one();
    exp_t h;
    @(negedge clk);
    check("drain_valid", 32'(bus.out_valid), 1);
    if (sb_q.size() == 0) begin
      check("drain_sb_empty", 1, 0);
    end else begin
      h = sb_q.pop_front();
      check("drain_seq",  32'(bus.out_seq),  h.seq);
      check("drain_addr", 32'(bus.out_addr), h.addr);
      check("drain_data", 32'(bus.out_data), h.data);
      m_count--;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_count"},    32'(count),         m_count);
    check({tag, "_overflow"}, 32'(overflow),      m_ovf);
    check({tag, "_valid"},    32'(bus.out_valid), (m_count > 0) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1;
    cap_en = 1'b0; filter_en = 1'b0; ovf_clr = 1'b0; shadow_sel = '0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_count",    32'(count),         0);
    check("rst_valid",    32'(bus.out_valid), 0);
    check("rst_overflow", 32'(overflow),      0);
    check("rst_seq",      32'(bus.out_seq),   0);
    check("rst_addr",     32'(bus.out_addr),  0);
    check("rst_data",     32'(bus.out_data),  0);
    check("rst_shadow",   32'(shadow_data),   0);
    reset = 1'b0;

    // Basic capture, no filter
    cap_en = 1'b1; filter_en = 1'b0;
    wb_write(1, 8'h11, 1'b0);
    wb_write(2, 8'h22, 1'b0);
    check_state("basic");
    drain_one();
    drain_one();
    check_state("basic_drained");

    // Filter suppresses unchanged values
    do_reset();
    filter_en = 1'b1;
    repeat (3) wb_write(3, 8'h05, 1'b0);
    wb_write(3, 8'h06, 1'b0);
    check_state("filter");
    drain_one();
    drain_one();
    shadow_sel = 2'd3;
    @(negedge clk);
    check("filter_shadow", 32'(shadow_data), 8'h06);

    // Overflow with seq gaps
    do_reset();
    filter_en = 1'b0;
    for (int i = 0; i < 10; i++) wb_write(i % 4, 8'h30 + i, 1'b0);
    check_state("ovf_full");
    for (int i = 0; i < 8; i++) drain_one();
    check_state("ovf_drained");
    wb_write(0, 8'h5A, 1'b0);
    drain_one();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    m_ovf = 0;
    check_state("ovf_clr");

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 8; i++) wb_write(i % 4, 8'h80 + i, 1'b0);
    check_state("full");
    wb_write(1, 8'hC3, 1'b1);
    check_state("full_pop_push");
    for (int i = 0; i < 8; i++) drain_one();
    check_state("full_drained");

    // Capture disabled; shadow still tracks
    do_reset();
    cap_en = 1'b0; filter_en = 1'b0;
    wb_write(0, 8'hAA, 1'b0);
    check_state("capdis");
    shadow_sel = 2'd0;
    @(negedge clk);
    check("capdis_shadow", 32'(shadow_data), 8'hAA);
    cap_en = 1'b1; filter_en = 1'b1;
    wb_write(0, 8'hAA, 1'b0);
    check_state("filter_same");

    // Asynchronous reset with entries queued
    filter_en = 1'b0;
    wb_write(1, 8'h01, 1'b0);
    wb_write(2, 8'h02, 1'b0);
    wb_write(3, 8'h03, 1'b0);
    check_state("pre_arst");
    shadow_sel = 2'd2;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid",    32'(bus.out_valid), 0);
    check("arst_count",    32'(count),         0);
    check("arst_overflow", 32'(overflow),      0);
    check("arst_shadow",   32'(shadow_data),   0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_state("post_arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_trace_capture.md
# wb_trace_capture

Writeback trace capture unit that sits on the pipelined CPU's writeback port (`wb_we`/`wb_addr`/`wb_data`) as its consumer. It keeps a shadow copy of the 4-entry register file, stamps each qualifying writeback with a sequence number, and buffers it in a FIFO. A debug host or testbench drains the FIFO over a valid/ready handshake, with sticky overflow reporting.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `DATA_W`, 8, writeback data width.
- `ADDR_W`, 2, register address width (shadow file has 2^ADDR_W entries).
- `SEQ_W`, 8, sequence-number width.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wb_we`  in  1  CPU writeback strobe.
- `wb_addr`  in  ADDR_W  writeback destination register.
- `wb_data`  in  DATA_W  writeback value.
- `cap_en`  in  1  capture enable; 0 = no events enter the FIFO (shadow still tracks).
- `filter_en`  in  1  1 = capture only writes that change the shadow value.
- `ovf_clr`  in  1  clears sticky overflow.
- `out_valid`  out  1  FIFO head entry present.
- `out_ready`  in  1  consumer accepts head.
- `out_seq`  out  SEQ_W  head entry sequence number.
- `out_addr`  out  ADDR_W  head entry register address.
- `out_data`  out  DATA_W  head entry data.
- `count`  out  clog2(DEPTH+1)  current FIFO occupancy.
- `overflow`  out  1  sticky: an event was dropped.
- `shadow_sel`  in  ADDR_W  shadow register select.
- `shadow_data`  out  DATA_W  shadow register value (combinational from `shadow_sel`).

## Operation
- Shadow file: on every `wb_we`=1, `shadow[wb_addr]` <= `wb_data` and `sh_vld[wb_addr]` <= 1, independent of `cap_en`/FIFO state.
- Event qualifies when `cap_en && wb_we && (!filter_en || !sh_vld[wb_addr] || wb_data != shadow[wb_addr])`; the comparison uses the pre-update shadow value.
- Every qualifying event increments `seq` (mod 2^SEQ_W), whether or not it is stored; gaps in `out_seq` therefore expose losses. Stored entry = {current `seq`, `wb_addr`, `wb_data`}, and `seq` then increments.
- Pop = `out_valid && out_ready`. Push = qualifying event and (not full, or pop in the same cycle).
- Full with qualifying event and no pop: entry dropped, `overflow` <= 1. `seq` still increments.
- Full with simultaneous pop and event: both occur; `count` unchanged; no overflow.
- Empty with simultaneous event and `out_ready`: no bypass; `out_valid` stays 0 this cycle.
- `overflow` set has priority over `ovf_clr` in the same cycle.
- `out_*` fields show the head entry when `out_valid`=1. Their values are don't-care when `out_valid`=0.
- Read/write pointers are clog2(DEPTH) bits and wrap naturally. Full/empty come from `count`.

## Timing
- Reset (async assert; release is synchronous to `clk`):
  - `count`=0, `out_valid`=0, `overflow`=0, `seq`=0, pointers=0.
  - All shadow entries 0, all `sh_vld`=0.
  - `out_seq`/`out_addr`/`out_data` read 0.
- Capture latency: an event sampled at edge N appears with `out_valid`=1 after edge N.
- `count` updates on the same edge as push/pop; throughput 1 push + 1 pop per cycle.
- Shadow update visible on `shadow_data` after the writing edge.
- `out_valid` holds and `out_*` stay stable until a pop.
- Reset mid-operation discards all FIFO contents and shadow state immediately (asynchronous).

## Test plan
- Reset, then `cap_en`=1, `filter_en`=0; writes r1=0x11 and r2=0x22 on consecutive cycles with `out_ready`=0 -> `count`=2; drain returns (seq0,r1,0x11) then (seq1,r2,0x22); `out_valid`=0 after.
- `filter_en`=1: write r3=0x05 three times, then r3=0x06 -> exactly two entries, (seq0,r3,0x05) and (seq1,r3,0x06); `shadow_sel`=3 reads 0x06.
- DEPTH=8, `out_ready`=0, 10 distinct writes -> `count`=8, `overflow`=1; drain gives seq 0..7. An 11th write after draining carries seq 10. `ovf_clr` then clears `overflow`.
- Full FIFO, `out_ready`=1 and a write in the same cycle -> `count` stays 8, `overflow` stays 0, new entry ordered last.
- `cap_en`=0 with write r0=0xAA -> `count`=0; `shadow_sel`=0 reads 0xAA. Then `cap_en`=1, `filter_en`=1, write r0=0xAA -> no entry.
- Assert `reset` asynchronously with 3 entries queued -> `out_valid`, `count`, `overflow`, and `shadow_data` drop to 0 before the next clock edge.
